// File: rtl/column_approx_div_pkg.sv
// Shared types and helpers for the column-truncated sequential divider.
package column_approx_div_pkg;

  localparam int DIV_LENGTH = 8;
  localparam int DIV_WIDTH  = 2 * DIV_LENGTH;
  localparam int DIV_THETA  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of low divisor bits cleared when computing quotient bit j.
  function automatic int trunc_shift(input int j, input int theta);
    return (j < theta) ? (theta - j) : 0;
  endfunction

endpackage

// File: rtl/column_approx_div_step.sv
// One restoring-division step with the truncated divisor for quotient bit j.
module column_approx_div_step
  import column_approx_div_pkg::*;
#(
  parameter int LENGTH = DIV_LENGTH,
  parameter int THETA  = DIV_THETA,
  parameter int CW     = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic [2*LENGTH-1:0] rem,
  input  logic [LENGTH-1:0]   y,
  input  logic [CW-1:0]       j,
  output logic [2*LENGTH-1:0] rem_next,
  output logic                q_bit
);

  int                  t;
  logic [LENGTH-1:0]   d;
  logic [2*LENGTH-1:0] dj;

  always_comb begin
    t  = trunc_shift(int'(j), THETA);
    d  = (y >> t) << t;
    dj = {{LENGTH{1'b0}}, d} << j;
    // R never grows, so a plain 2*LENGTH-bit compare/subtract is enough.
    q_bit    = (rem >= dj);
    rem_next = q_bit ? (rem - dj) : rem;
  end

endmodule

// File: rtl/column_approx_div_seq.sv
// Sequential column-truncated restoring divider, one quotient bit per cycle, MSB first.
module column_approx_div_seq
  import column_approx_div_pkg::*;
#(
  parameter int LENGTH = DIV_LENGTH,
  parameter int THETA  = DIV_THETA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*LENGTH-1:0] x,
  input  logic [LENGTH-1:0]   y,
  output logic                busy,
  output logic                done,
  output logic [LENGTH-1:0]   q,
  output logic [2*LENGTH-1:0] r,
  output logic                dz,
  output logic                ovf
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  state_t              state;
  logic [LENGTH-1:0]   y_reg;
  logic [2*LENGTH-1:0] rem;
  logic [CW-1:0]       cnt;
  logic [2*LENGTH-1:0] rem_next;
  logic                q_bit;

  column_approx_div_step #(
    .LENGTH(LENGTH),
    .THETA (THETA),
    .CW    (CW)
  ) u_step (
    .rem     (rem),
    .y       (y_reg),
    .j       (cnt),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  // The working remainder doubles as the held remainder output.
  assign r = rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      rem   <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      y_reg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            y_reg <= y;
            rem   <= x;
            dz    <= 1'b0;
            ovf   <= 1'b0;
            if (y == '0) begin
              dz    <= 1'b1;
              q     <= '1;
              done  <= 1'b1;
              state <= DONE;
            end else if (x >= {y, {LENGTH{1'b0}}}) begin
              // Exact (untruncated) check: the quotient would not fit in LENGTH bits.
              ovf   <= 1'b1;
              q     <= '1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              q     <= '0;
              cnt   <= CW'(LENGTH - 1);
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem    <= rem_next;
          q[cnt] <= q_bit;
          if (cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_column_approx_div_seq.sv
// Bench for column_approx_div_seq: a THETA=7 and a THETA=0 instance driven with the same stimulus.
module tb_column_approx_div_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] x;
  logic [7:0]  y;

  logic        busy7, done7, dz7, ovf7;
  logic [7:0]  q7;
  logic [15:0] r7;
  logic        busy0, done0, dz0, ovf0;
  logic [7:0]  q0;
  logic [15:0] r0;

  int checks = 0;
  int errors = 0;

  // Expected record layout: {dz, ovf, q[7:0], r[15:0]}
  logic [25:0] exp_q7[$];
  logic [25:0] exp_q0[$];

  typedef struct {
    logic [15:0] x;
    logic [7:0]  y;
    logic [25:0] e7;
    logic [25:0] e0;
  } vec_t;

  column_approx_div_seq #(.LENGTH(8), .THETA(7)) dut7 (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy7), .done(done7), .q(q7), .r(r7), .dz(dz7), .ovf(ovf7)
  );

  column_approx_div_seq #(.LENGTH(8), .THETA(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy0), .done(done0), .q(q0), .r(r0), .dz(dz0), .ovf(ovf0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  // ---------------- helpers ----------------
  function automatic logic [25:0] pack(input logic d, input logic o,
                                       input logic [7:0] qq, input logic [15:0] rr);
    return {d, o, qq, rr};
  endfunction

  // Behavioural reference of the truncated restoring algorithm.
  function automatic logic [25:0] model(input logic [15:0] xi, input logic [7:0] yi,
                                        input int theta);
    logic [15:0] rr;
    logic [15:0] dd;
    logic [7:0]  qq;
    int          t;
    if (yi == 8'd0) return pack(1'b1, 1'b0, 8'hFF, xi);
    if (xi >= {yi, 8'h00}) return pack(1'b0, 1'b1, 8'hFF, xi);
    rr = xi;
    qq = 8'd0;
    for (int j = 7; j >= 0; j--) begin
      t  = (j < theta) ? (theta - j) : 0;
      dd = {8'd0, yi};
      dd = ((dd >> t) << t) << j;
      if (rr >= dd) begin
        rr    = rr - dd;
        qq[j] = 1'b1;
      end
    end
    return pack(1'b0, 1'b0, qq, rr);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && done7) begin
      if (exp_q7.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL t7_unexpected_done got=%0h exp=none", {dz7, ovf7, q7, r7});
      end else begin
        check("t7_result", {6'd0, dz7, ovf7, q7, r7}, {6'd0, exp_q7.pop_front()});
      end
      check("t7_busy_at_done", {31'd0, busy7}, 32'd0);
    end
    if (!rst && done0) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL t0_unexpected_done got=%0h exp=none", {dz0, ovf0, q0, r0});
      end else begin
        check("t0_result", {6'd0, dz0, ovf0, q0, r0}, {6'd0, exp_q0.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Starts one division, waits for done, checks latency and busy length,
  // then steps one more cycle so the DUT is back in IDLE.
  task automatic run_one(input logic [15:0] xi, input logic [7:0] yi,
                         input logic [25:0] e7, input logic [25:0] e0);
    int edges;
    int busy_cnt;
    int lat;
    lat = (e7[25] || e7[24]) ? 1 : 9;
    exp_q7.push_back(e7);
    exp_q0.push_back(e0);
    x = xi;
    y = yi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    busy_cnt = 0;
    while (!done7 && edges < 30) begin
      if (busy7) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    if (!done7) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got=%0d exp=%0d", edges, lat);
    end
    check("latency", edges, lat);
    check("busy_cycles", busy_cnt, (lat == 1) ? 0 : 8);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done7 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done7) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=%0d exp=done", name, n);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[7];

  initial begin
    logic [7:0]  ry;
    logic [15:0] rx;

    vecs[0] = '{16'd1000,  8'd10,   pack(0, 0, 8'h6F, 16'd104),  pack(0, 0, 8'd100, 16'd0)};
    vecs[1] = '{16'hFE01,  8'hFF,   pack(0, 0, 8'hFF, 16'd769),  pack(0, 0, 8'hFF, 16'd0)};
    vecs[2] = '{16'h1234,  8'h00,   pack(1, 0, 8'hFF, 16'h1234), pack(1, 0, 8'hFF, 16'h1234)};
    vecs[3] = '{16'hFF00,  8'h80,   pack(0, 1, 8'hFF, 16'hFF00), pack(0, 1, 8'hFF, 16'hFF00)};
    vecs[4] = '{16'h7FFF,  8'h80,   pack(0, 0, 8'hFF, 16'h007F), pack(0, 0, 8'hFF, 16'h007F)};
    vecs[5] = '{16'h0000,  8'h01,   pack(0, 0, 8'h7F, 16'h0000), pack(0, 0, 8'h00, 16'h0000)};
    vecs[6] = '{16'hFFFF,  8'hFF,   pack(0, 1, 8'hFF, 16'hFFFF), pack(0, 1, 8'hFF, 16'hFFFF)};

    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state7", {22'd0, busy7, done7, dz7, ovf7, q7, r7}, 32'd0);
    check("reset_state0", {22'd0, busy0, done0, dz0, ovf0, q0, r0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      run_one(vecs[i].x, vecs[i].y, vecs[i].e7, vecs[i].e0);
    end

    // Results hold in IDLE until the next start
    repeat (3) @(posedge clk);
    #1;
    check("hold_q7", {24'd0, q7}, 32'hFF);
    check("hold_r7", {16'd0, r7}, 32'hFFFF);
    check("hold_ovf7", {31'd0, ovf7}, 32'd1);

    // Start pulsed during RUN is ignored; start right after done is accepted
    exp_q7.push_back(pack(0, 0, 8'h6F, 16'd104));
    exp_q0.push_back(pack(0, 0, 8'd100, 16'd0));
    x = 16'd1000;
    y = 8'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    x = 16'h1234;
    y = 8'h33;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore_start");
    @(posedge clk);
    #1;
    run_one(16'd500, 8'd7, pack(0, 0, 8'h5F, 16'd116), pack(0, 0, 8'd71, 16'd3));

    // Reset during RUN aborts without a done pulse
    x = 16'd1000;
    y = 8'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_outputs7", {22'd0, busy7, done7, dz7, ovf7, q7, r7}, 32'd0);
    check("abort_outputs0", {22'd0, busy0, done0, dz0, ovf0, q0, r0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_abort", {31'd0, done7}, 32'd0);
    run_one(16'd1000, 8'd10, pack(0, 0, 8'h6F, 16'd104), pack(0, 0, 8'd100, 16'd0));

    // Random sweep of non-overflowing operands
    for (int i = 0; i < 24; i++) begin
      ry = 8'($urandom_range(1, 255));
      rx = 16'($urandom_range(0, ({16'd0, ry} << 8) - 1));
      run_one(rx, ry, model(rx, ry, 7), pack(0, 0, 8'(rx / {8'd0, ry}), rx % {8'd0, ry}));
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue7_drained", exp_q7.size(), 0);
    check("queue0_drained", exp_q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/column_approx_div_seq.md
Name: column_approx_div_seq

Overview:
- Sequential restoring divider: the inverse operation of the column-truncated approximate multiplier family.
- Divides a 2*LENGTH-bit dividend by a LENGTH-bit divisor and produces a LENGTH-bit quotient and a 2*LENGTH-bit remainder, one quotient bit per cycle, MSB first.
- Column truncation mirrors the multiplier. The trial subtraction for quotient bit j uses the divisor with its low max(0, THETA-j) bits cleared.
- Used to measure approximate multiply/divide round-trip error and as a low-area divider in the approximate arithmetic library.

Parameters:
- LENGTH, 8, divisor/quotient width; dividend and remainder are 2*LENGTH bits.
- THETA, 7, truncation depth; legal range 0..LENGTH-1; THETA=0 gives exact division.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only while idle
- x  in  2*LENGTH  dividend, captured on accepted start
- y  in  LENGTH  divisor, captured on accepted start
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse; results valid from this cycle on
- q  out  LENGTH  quotient, held until the next accepted start
- r  out  2*LENGTH  remainder, held until the next accepted start
- dz  out  1  divide-by-zero flag, held with q/r
- ovf  out  1  quotient-overflow flag, held with q/r

Behaviour:
- States: IDLE, RUN, DONE.
- Reset, asynchronous: state=IDLE; busy=0, done=0, q=0, r=0, dz=0, ovf=0; step counter=0.
- IDLE with start=1: capture x and y; clear dz and ovf. Next state:
  - y==0 -> DONE with dz=1, q=all ones, r=x.
  - else x >= (y << LENGTH), compared exactly with no truncation -> DONE with ovf=1, q=all ones, r=x.
  - else -> RUN with R=x, j=LENGTH-1, q=0.
- RUN, one step per cycle:
  - t = THETA-j if j<THETA, else 0.
  - D_j = (y >> t) << t.
  - If R >= (D_j << j): R -= (D_j << j) and q[j]=1; else q[j]=0.
  - If j==0 -> DONE; else j -= 1.
- Compare and subtract are 2*LENGTH bits wide. R never increases, so there is no overflow.
- D_j==0 is legal: the compare always passes and q[j]=1.
- DONE: done=1 for exactly one cycle; r=R; busy=0 in this cycle; next state IDLE.
- Latency from the start-sampling edge:
  - Normal: done asserts after LENGTH+1 edges (9 for LENGTH=8).
  - dz/ovf: done asserts after 1 edge.
- busy=1 for exactly the LENGTH RUN cycles. start while RUN or DONE is ignored and not queued.
- Back-to-back: start in the cycle after done is accepted.
- q, r, dz, ovf are stable from done until the next accepted start. During RUN, q and r may show partial values; consumers qualify them with done.
- Approximate results: r can be >= y and q can exceed the exact quotient. Both are reported raw, with no correction step.
- Reset mid-RUN aborts immediately to IDLE with all outputs cleared; no done pulse is issued.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE};
  - localparam helper giving the truncation shift t(j, THETA);
  - width localparams LENGTH and 2*LENGTH.
- One natural sub-module, column_approx_div_step: combinational step with inputs R, y, j and outputs R_next, q_bit. The top level holds the FSM and registers.

Test Plan:
- THETA=7, x=1000, y=10 -> done at edge 9, q=0x6F (111), r=104, dz=0, ovf=0; busy high 8 cycles.
- THETA=0, x=1000, y=10 -> q=100, r=0 (exact); a random sweep matches the golden x/y and x%y.
- THETA=7, x=0xFE01, y=0xFF -> q=0xFF, r=769; ovf=0, since 0xFE01 < 0xFF00.
- y=0, x=0x1234 -> done 1 cycle after start, dz=1, q=0xFF, r=0x1234. Then x=0xFF00, y=0x80 -> ovf=1, q=0xFF, r=0xFF00.
- start pulsed during RUN with different x/y -> ignored, and the first result is unchanged. start the cycle after done -> accepted; second result correct.
- rst asserted at RUN step 4 -> outputs 0 immediately, no done pulse. A subsequent start produces the correct result.
